// File: rtl/pipe_multfu_pkg.sv
// Shared FU package: multiply mode encoding and per-stage control payload.
package pipe_multfu_pkg;

  localparam int unsigned WBS_W      = 8;
  localparam int unsigned MAX_STAGES = 8;

  typedef enum logic [1:0] {
    MUL_LO  = 2'b00,
    MUL_HU  = 2'b01,
    MUL_HS  = 2'b10,
    MUL_HSU = 2'b11
  } mul_mode_e;

  typedef struct packed {
    logic             valid;
    mul_mode_e        mode;
    logic [WBS_W-1:0] wbs;
  } stage_ctl_t;

  function automatic logic mode_a_signed(input mul_mode_e m);
    return (m == MUL_HS) || (m == MUL_HSU);
  endfunction

  function automatic logic mode_b_signed(input mul_mode_e m);
    return (m == MUL_HS);
  endfunction

endpackage

// File: rtl/pipe_multfu_mult_core.sv
// Combinational full-width product with per-operand signedness chosen by mode.
module mult_core
  import pipe_multfu_pkg::*;
#(
  parameter int unsigned DATA_W = 8
) (
  input  logic [DATA_W-1:0]   a,
  input  logic [DATA_W-1:0]   b,
  input  logic [1:0]          mode,
  output logic [2*DATA_W-1:0] product
);

  mul_mode_e           m;
  logic [2*DATA_W-1:0] a_ext;
  logic [2*DATA_W-1:0] b_ext;

  // Extending both operands to 2*DATA_W makes one unsigned multiply give the
  // correct two's-complement low half for every signedness combination.
  always_comb begin
    m       = mul_mode_e'(mode);
    a_ext   = {{DATA_W{mode_a_signed(m) & a[DATA_W-1]}}, a};
    b_ext   = {{DATA_W{mode_b_signed(m) & b[DATA_W-1]}}, b};
    product = a_ext * b_ext;
  end

endmodule

// File: rtl/pipe_multfu.sv
// Pipelined multiply FU: STAGES-deep globally stalled pipeline whose output
// register feeds both a CDB and a ROB port, each with its own accept.
module pipe_multfu
  import pipe_multfu_pkg::*;
#(
  parameter int unsigned DATA_W  = 8,
  parameter int unsigned ROBID_W = 4,
  parameter int unsigned FLAGS_W = 8,
  parameter int unsigned STAGES  = 3
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   input_transmit,
  input  logic [7:0]             operand,
  input  logic [1:0][DATA_W-1:0] depvals,
  input  logic [WBS_W-1:0]       wbs,
  input  logic [FLAGS_W-1:0]     flags,
  input  logic [ROBID_W-1:0]     robid,
  input  logic                   flush,
  input  logic                   cdb_transmit,
  input  logic                   rob_transmit,
  output logic                   cdb_transmit_out,
  output logic [ROBID_W-1:0]     cdb_id,
  output logic [DATA_W-1:0]      cdb_val,
  output logic                   rob_transmit_out,
  output logic [ROBID_W-1:0]     robid_out,
  output logic [FLAGS_W-1:0]     flags_out,
  output logic [WBS_W-1:0]       wbs_out,
  output logic [DATA_W-1:0]      value_out,
  output logic                   busy
);

  localparam int unsigned PROD_W = 2 * DATA_W;
  localparam int unsigned LAST   = STAGES - 1;

  stage_ctl_t         st_ctl   [STAGES];
  logic [ROBID_W-1:0] st_robid [STAGES];
  logic [FLAGS_W-1:0] st_flags [STAGES];
  logic [PROD_W-1:0]  st_prod  [STAGES];

  logic              cdb_done;
  logic              rob_done;
  logic [PROD_W-1:0] product;
  stage_ctl_t        issue_ctl;
  logic              out_valid;
  logic              cdb_fire;
  logic              rob_fire;
  logic              retire;
  logic              advance;

  mult_core #(
    .DATA_W (DATA_W)
  ) u_mult_core (
    .a       (depvals[0]),
    .b       (depvals[1]),
    .mode    (operand[1:0]),
    .product (product)
  );

  always_comb begin
    issue_ctl.valid = input_transmit;
    issue_ctl.mode  = mul_mode_e'(operand[1:0]);
    issue_ctl.wbs   = wbs;
  end

  // Retirement counts this cycle's accepts, so the pipe can shift in the
  // same cycle the last outstanding side takes the result.
  always_comb begin
    out_valid        = st_ctl[LAST].valid;
    cdb_transmit_out = out_valid & ~cdb_done;
    rob_transmit_out = out_valid & ~rob_done;
    cdb_fire         = cdb_transmit_out & cdb_transmit;
    rob_fire         = rob_transmit_out & rob_transmit;
    retire           = out_valid & (cdb_done | cdb_fire) & (rob_done | rob_fire);
    advance          = ~out_valid | retire;
    busy             = ~advance;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < STAGES; i++) begin
        st_ctl[i]   <= '0;
        st_robid[i] <= '0;
        st_flags[i] <= '0;
        st_prod[i]  <= '0;
      end
      cdb_done <= 1'b0;
      rob_done <= 1'b0;
    end else if (flush) begin
      for (int unsigned i = 0; i < STAGES; i++) begin
        st_ctl[i].valid <= 1'b0;
      end
      cdb_done <= 1'b0;
      rob_done <= 1'b0;
    end else if (advance) begin
      st_ctl[0]   <= issue_ctl;
      st_robid[0] <= robid;
      st_flags[0] <= flags;
      st_prod[0]  <= product;
      for (int unsigned i = 1; i < STAGES; i++) begin
        st_ctl[i]   <= st_ctl[i-1];
        st_robid[i] <= st_robid[i-1];
        st_flags[i] <= st_flags[i-1];
        st_prod[i]  <= st_prod[i-1];
      end
      cdb_done <= 1'b0;
      rob_done <= 1'b0;
    end else begin
      if (cdb_fire) cdb_done <= 1'b1;
      if (rob_fire) rob_done <= 1'b1;
    end
  end

  always_comb begin
    robid_out = st_robid[LAST];
    flags_out = st_flags[LAST];
    wbs_out   = st_ctl[LAST].wbs;
    if (st_ctl[LAST].mode == MUL_LO) value_out = st_prod[LAST][DATA_W-1:0];
    else                             value_out = st_prod[LAST][PROD_W-1:DATA_W];
    cdb_id  = robid_out;
    cdb_val = value_out;
  end

endmodule

// File: doc/pipe_multfu.md
PIPE_MULTFU -- requirements
Module: pipe_multfu

Interface
REQ-001 SHALL take parameter DATA_W, default 8: operand/result width.
REQ-002 SHALL take parameter ROBID_W, default 4: ROB tag width.
REQ-003 SHALL take parameter FLAGS_W, default 8: flags field width.
REQ-004 SHALL take parameter STAGES, default 3, legal 1..8: pipeline depth in registers, including the output register.
REQ-005 SHALL have one clock and an asynchronous, active-high reset: clk  in  1  clock; rst  in  1  asynchronous active-high reset.
REQ-006 SHALL have input ports input_transmit (1, issue valid), operand (8, mode select, bits [1:0] used) and depvals (2 x DATA_W, [0]=a, [1]=b).
REQ-007 SHALL have input ports wbs (8, writeback register), flags (FLAGS_W, passthrough) and robid (ROBID_W, tag).
REQ-008 SHALL have input ports flush (1, kill all in-flight ops), cdb_transmit (1, CDB accept) and rob_transmit (1, ROB accept).
REQ-009 SHALL have CDB outputs cdb_transmit_out (1, valid), cdb_id (ROBID_W) and cdb_val (DATA_W).
REQ-010 SHALL have ROB outputs rob_transmit_out (1, valid), robid_out (ROBID_W), flags_out (FLAGS_W), wbs_out (8) and value_out (DATA_W).
REQ-011 SHALL have output busy (1): the issue is not accepted this cycle.

Function
REQ-012 SHALL accept an op on a rising clk edge when input_transmit=1 and busy=0; input_transmit while busy=1 is ignored and the source holds.
REQ-013 SHALL select the product by operand[1:0]: 00 low DATA_W bits, unsigned; 01 high bits, unsigned x unsigned; 10 high bits, signed x signed; 11 high bits, signed a x unsigned b.
REQ-014 SHALL form the full 2*DATA_W product with no overflow or saturation; operand[7:2] is ignored.
REQ-015 SHALL carry valid, robid, wbs, flags, mode and partial product through every stage alongside the data.
REQ-016 SHALL present an op accepted at edge N on the outputs after edge N+STAGES-1 when there is no stall (latency STAGES cycles).
REQ-017 SHALL drive both output sides from the same output register: cdb_id=robid_out, cdb_val=value_out, and flags_out=flags unchanged.
REQ-018 SHALL keep cdb_done and rob_done bits per output entry; a side's valid output = entry valid and that side not done.
REQ-019 SHALL set a side's done bit on the edge where its valid and accept are both 1; accepts while that side's valid=0 are ignored.
REQ-020 SHALL retire the output entry when both sides are done, counting acceptances in the current cycle; both accepts in one cycle retire it in that cycle.
REQ-021 SHALL advance the pipeline, shifting all stages, when the output entry is empty or retires this cycle; otherwise all stages hold (global stall, no bubble collapse).
REQ-022 SHALL drive busy = not advance, combinationally from state and the accept inputs.
REQ-023 SHALL hold all output values stable while a side's valid is high and not accepted.
REQ-024 SHALL, on flush=1, clear every stage valid bit and both done bits at the next edge; an issue in the same cycle is dropped and the outputs show valid=0 the following cycle.
REQ-025 SHALL leave ops accepted after the flush edge unaffected.
REQ-026 SHALL, with STAGES=1, make the output register the only stage; throughput is 1 op/cycle when both sides accept each cycle.

Reset
REQ-027 SHALL, with rst=1, asynchronously clear all valid and done bits.
REQ-028 SHALL, with rst=1, force cdb_transmit_out=0, rob_transmit_out=0 and all data/tag outputs to 0.
REQ-029 SHALL drive busy=0 once out of reset.
REQ-030 SHALL, on reset mid-operation, discard in-flight ops with no partial output.

Structure
REQ-031 SHALL place the mode enum (MUL_LO, MUL_HU, MUL_HS, MUL_HSU) and the stage payload struct typedef in the shared FU package.
REQ-032 SHALL implement one sub-module, mult_core: a combinational signed/unsigned product feeding the stage registers.

Verification (DATA_W=8, STAGES=3)
REQ-033 SHALL cover: issue a=0x0F b=0x11 mode 00 robid=5, both accepts held 1 -> cdb_val=value_out=0xFF, cdb_id=5 exactly 3 cycles later.
REQ-034 SHALL cover: a=0x80 b=0x80 in modes 01 and 10 -> 0x40 both; a=0xFF b=0x02 in mode 10 -> 0xFF, mode 01 -> 0x01, mode 11 -> 0xFF.
REQ-035 SHALL cover: 4 back-to-back issues with rob_transmit=0 -> busy rises, CDB output goes low after one accept, nothing is lost; rob_transmit=1 -> results in issue order.
REQ-036 SHALL cover: cdb_transmit and rob_transmit accepting on different cycles -> entry retires only after the second accept, with each value seen once per side.
REQ-037 SHALL cover: flush with 3 ops in flight plus a same-cycle issue -> no outputs; the next issue completes normally with latency 3.
REQ-038 SHALL cover: rst pulse asserted mid-stall and asynchronous to clk -> all outputs 0 immediately and busy=0 after release.
